// File: rtl/spi_word_tx.sv
// SPI master: sends WORDS 16-bit words MSB-first (CS low, SCK idle low, MOSI changes on SCK fall).
// Defining SPI_TX_CHECKSUM_EN appends one word holding the mod-2^16 sum of the payload.
module spi_word_tx #(
   parameter int WORDS       = 5,
   parameter int HALF_PERIOD = 6,
   parameter int GAP_CYCLES  = 16
) (
   input  logic                i_Clock,
   input  logic                i_Reset_N,
   input  logic [16*WORDS-1:0] i_Data,
   input  logic                i_Start,
   output logic                o_Busy,
   output logic                o_Done,
   output logic                o_SPI_CS,
   output logic                o_SPI_Clock,
   output logic                o_SPI_Data
);

`ifdef SPI_TX_CHECKSUM_EN
   localparam int NWORDS = WORDS + 1;
   localparam logic [3:0] LAST_PAYLOAD = 4'(WORDS - 1);
`else
   localparam int NWORDS = WORDS;
`endif
   localparam int HW = $clog2(HALF_PERIOD);
   localparam int GW = $clog2(GAP_CYCLES + 1);
   localparam logic [HW-1:0] HALF_LAST = HW'(HALF_PERIOD - 1);
   localparam logic [GW-1:0] GAP_LAST  = GW'(GAP_CYCLES - 1);
   localparam logic [3:0]    LAST_WORD = 4'(NWORDS - 1);

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_SETUP  = 3'd1;
   localparam logic [2:0] S_SCK_HI = 3'd2;
   localparam logic [2:0] S_SCK_LO = 3'd3;
   localparam logic [2:0] S_GAP    = 3'd4;

   logic [2:0]          state_q, state_d;
   logic [HW-1:0]       half_q, half_d;
   logic [GW-1:0]       gap_q, gap_d;
   logic [3:0]          bit_q, bit_d;
   logic [3:0]          word_q, word_d;
   logic [15:0]         shift_q, shift_d;
   logic [16*WORDS-1:0] frame_q, frame_d;
   logic                last_q, last_d;
   logic                cs_q, cs_d;
   logic                sck_q, sck_d;
   logic                mosi_q, mosi_d;
   logic                busy_q, busy_d;
   logic                done_q, done_d;
   logic [15:0]         nxt_word;
`ifdef SPI_TX_CHECKSUM_EN
   logic [15:0]         sum_q, sum_d;
`endif

   always_comb begin
      state_d  = state_q;
      half_d   = half_q;
      gap_d    = gap_q;
      bit_d    = bit_q;
      word_d   = word_q;
      shift_d  = shift_q;
      frame_d  = frame_q;
      last_d   = last_q;
      cs_d     = cs_q;
      sck_d    = sck_q;
      mosi_d   = mosi_q;
      busy_d   = busy_q;
      done_d   = 1'b0;
      nxt_word = frame_q[15:0];
`ifdef SPI_TX_CHECKSUM_EN
      sum_d    = sum_q;
      if (word_q == LAST_PAYLOAD) nxt_word = sum_q;
`endif

      case (state_q)
         S_IDLE: begin
            // Busy while still in IDLE means a frame was latched on the previous edge.
            if (busy_q) begin
               state_d = S_SETUP;
               cs_d    = 1'b0;
               mosi_d  = shift_q[15];
               half_d  = '0;
               bit_d   = '0;
               word_d  = '0;
               last_d  = 1'b0;
            end else if (i_Start) begin
               busy_d  = 1'b1;
               shift_d = i_Data[15:0];
               frame_d = i_Data >> 16;
`ifdef SPI_TX_CHECKSUM_EN
               sum_d   = i_Data[15:0];
`endif
            end
         end

         S_SETUP: begin
            if (half_q == HALF_LAST) begin
               state_d = S_SCK_HI;
               sck_d   = 1'b1;
               half_d  = '0;
            end else begin
               half_d = half_q + 1'b1;
            end
         end

         S_SCK_HI: begin
            if (half_q == HALF_LAST) begin
               state_d = S_SCK_LO;
               sck_d   = 1'b0;
               half_d  = '0;
               bit_d   = bit_q + 4'd1;
               if (bit_q == 4'd15) begin
                  if (word_q == LAST_WORD) begin
                     // Final low phase doubles as CS hold time with MOSI parked low.
                     last_d = 1'b1;
                     mosi_d = 1'b0;
                  end else begin
                     word_d  = word_q + 4'd1;
                     shift_d = nxt_word;
                     mosi_d  = nxt_word[15];
                     frame_d = frame_q >> 16;
`ifdef SPI_TX_CHECKSUM_EN
                     if (word_q != LAST_PAYLOAD) sum_d = sum_q + frame_q[15:0];
`endif
                  end
               end else begin
                  shift_d = {shift_q[14:0], 1'b0};
                  mosi_d  = shift_q[14];
               end
            end else begin
               half_d = half_q + 1'b1;
            end
         end

         S_SCK_LO: begin
            if (half_q == HALF_LAST) begin
               half_d = '0;
               if (last_q) begin
                  state_d = S_GAP;
                  cs_d    = 1'b1;
                  done_d  = 1'b1;
                  gap_d   = '0;
               end else begin
                  state_d = S_SCK_HI;
                  sck_d   = 1'b1;
               end
            end else begin
               half_d = half_q + 1'b1;
            end
         end

         S_GAP: begin
            if (gap_q == GAP_LAST) begin
               state_d = S_IDLE;
               busy_d  = 1'b0;
            end else begin
               gap_d = gap_q + 1'b1;
            end
         end

         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge i_Clock or negedge i_Reset_N) begin
      if (!i_Reset_N) begin
         state_q <= S_IDLE;
         half_q  <= '0;
         gap_q   <= '0;
         bit_q   <= '0;
         word_q  <= '0;
         shift_q <= '0;
         frame_q <= '0;
         last_q  <= 1'b0;
         cs_q    <= 1'b1;
         sck_q   <= 1'b0;
         mosi_q  <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
`ifdef SPI_TX_CHECKSUM_EN
         sum_q   <= '0;
`endif
      end else begin
         state_q <= state_d;
         half_q  <= half_d;
         gap_q   <= gap_d;
         bit_q   <= bit_d;
         word_q  <= word_d;
         shift_q <= shift_d;
         frame_q <= frame_d;
         last_q  <= last_d;
         cs_q    <= cs_d;
         sck_q   <= sck_d;
         mosi_q  <= mosi_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
`ifdef SPI_TX_CHECKSUM_EN
         sum_q   <= sum_d;
`endif
      end
   end

   assign o_Busy      = busy_q;
   assign o_Done      = done_q;
   assign o_SPI_CS    = cs_q;
   assign o_SPI_Clock = sck_q;
   assign o_SPI_Data  = mosi_q;

endmodule
